// File: rtl/cnt_seq_pkg.sv
// Shared types for the counter sequencer: FSM states, the step-table entry
// layout and its field widths.
package cnt_seq_pkg;

    localparam int VAL_W  = 6;
    localparam int STEP_W = 2 * VAL_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DWELL
    } state_t;

    typedef struct packed {
        logic             dir;
        logic [VAL_W-1:0] end_val;
        logic [VAL_W-1:0] start_val;
    } step_t;

    // Power-on entry: count up, 0 -> 0.
    localparam step_t STEP_RESET = 13'h1000;

    function automatic int dwell_ticks(input int f_clk_hz, input int dwell_ms);
        int t;
        t = f_clk_hz / 1000 * dwell_ms;
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/cnt_seq_ctrl_step_table.sv
// Step table: N_STEPS x step_t register file with one synchronous write port
// and one combinational read port.
module step_table
    import cnt_seq_pkg::*;
#(
    parameter  int N_STEPS = 4,
    localparam int ADDR_W  = $clog2(N_STEPS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  step_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output step_t             rdata
);

    step_t entries_q [N_STEPS];
    step_t entries_d [N_STEPS];

    always_comb begin
        entries_d = entries_q;
        if (we) begin
            entries_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_STEPS; i++) begin
                entries_q[i] <= STEP_RESET;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    assign rdata = entries_q[raddr];

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencer that walks an external 6-bit preset counter through a table of
// {direction, start, end} steps, pausing DWELL_TKS cycles after each step.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter  int F_CLK_HZ = 25_000_000,
    parameter  int DWELL_MS = 500,
    parameter  int N_STEPS  = 4,
    localparam int IDX_W    = $clog2(N_STEPS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [12:0]      cfg_data,
    input  logic [5:0]       q_in,
    output logic             cnt_load_n,
    output logic [5:0]       cnt_preset,
    output logic             cnt_run,
    output logic             cnt_up,
    output logic             busy,
    output logic [IDX_W-1:0] step_idx,
    output logic             done
);

    localparam int                DWELL_TKS  = dwell_ticks(F_CLK_HZ, DWELL_MS);
    localparam int                DW_W       = $clog2(DWELL_TKS + 1);
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_TKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_STEPS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [VAL_W-1:0]   end_val_q, end_val_d;
    logic               cnt_load_n_q, cnt_load_n_d;
    logic [VAL_W-1:0]   cnt_preset_q, cnt_preset_d;
    logic               cnt_run_q, cnt_run_d;
    logic               cnt_up_q, cnt_up_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    step_t              rd_step;

    // The table is addressed with the next index so LOAD outputs can be registered on entry.
    step_table #(.N_STEPS(N_STEPS)) u_table (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (cfg_we && (state_q == S_IDLE)),
        .waddr   (cfg_addr),
        .wdata   (step_t'(cfg_data)),
        .raddr   (idx_d),
        .rdata   (rd_step)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        end_val_d    = end_val_q;
        cnt_up_d     = cnt_up_q;
        cnt_preset_d = cnt_preset_q;
        cnt_load_n_d = 1'b1;
        cnt_run_d    = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: state_d = (q_in == end_val_q) ? S_DWELL : S_RUN;
            S_RUN: begin
                if (q_in == end_val_q) begin
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (dwell_q == DWELL_LAST) begin
                    if (idx_q != IDX_LAST) begin
                        state_d = S_LOAD;
                        idx_d   = idx_q + 1'b1;
                    end else if (loop_en) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && stop) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
        end

        // Outputs follow the state being entered, so every output is a flop.
        dwell_d = ((state_q == S_DWELL) && (state_d == S_DWELL)) ? dwell_q + 1'b1 : '0;
        busy_d  = (state_d != S_IDLE);
        if (state_d == S_IDLE) begin
            cnt_preset_d = '0;
            cnt_up_d     = 1'b1;
        end else if (state_d == S_LOAD) begin
            cnt_load_n_d = 1'b0;
            cnt_preset_d = rd_step.start_val;
            end_val_d    = rd_step.end_val;
            cnt_up_d     = rd_step.dir;
        end else if (state_d == S_RUN) begin
            cnt_run_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            dwell_q      <= '0;
            end_val_q    <= '0;
            cnt_load_n_q <= 1'b1;
            cnt_preset_q <= '0;
            cnt_run_q    <= 1'b0;
            cnt_up_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dwell_q      <= dwell_d;
            end_val_q    <= end_val_d;
            cnt_load_n_q <= cnt_load_n_d;
            cnt_preset_q <= cnt_preset_d;
            cnt_run_q    <= cnt_run_d;
            cnt_up_q     <= cnt_up_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cnt_load_n = cnt_load_n_q;
    assign cnt_preset = cnt_preset_q;
    assign cnt_run    = cnt_run_q;
    assign cnt_up     = cnt_up_q;
    assign busy       = busy_q;
    assign step_idx   = idx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: a behavioural 6-bit preset counter that ticks every
// 8 cycles, plus a queue of expected counter values checked on every load/tick.
module tb_cnt_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [12:0] cfg_data = 13'd0;
    logic [5:0]  q = 6'd0;
    logic        cnt_load_n;
    logic [5:0]  cnt_preset;
    logic        cnt_run;
    logic        cnt_up;
    logic        busy;
    logic [1:0]  step_idx;
    logic        done;

    int          assertCount = 0;
    int          failCount = 0;
    int          doneCount = 0;
    int          runCount = 0;
    logic [5:0]  expQ[$];
    logic        sbEn = 1'b0;
    logic        ev = 1'b0;
    logic [2:0]  tick = 3'd0;

    cnt_seq_ctrl #(.F_CLK_HZ(4000), .DWELL_MS(1), .N_STEPS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .q_in       (q),
        .cnt_load_n (cnt_load_n),
        .cnt_preset (cnt_preset),
        .cnt_run    (cnt_run),
        .cnt_up     (cnt_up),
        .busy       (busy),
        .step_idx   (step_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Counter model: load has priority, counting ticks every 8 run cycles.
    always @(posedge clk) begin
        ev <= 1'b0;
        if (!cnt_load_n) begin
            q    <= cnt_preset;
            tick <= 3'd0;
            ev   <= 1'b1;
        end else if (cnt_run) begin
            if (tick == 3'd7) begin
                tick <= 3'd0;
                q    <= cnt_up ? q + 6'd1 : q - 6'd1;
                ev   <= 1'b1;
            end else begin
                tick <= tick + 3'd1;
            end
        end else begin
            tick <= 3'd0;
        end
    end

    // Scoreboard side: each counter update is compared against the queue head.
    always @(negedge clk) begin
        if (done) doneCount++;
        if (cnt_run) runCount++;
        if (ev && sbEn) begin
            if (expQ.size() == 0) checkOutput("sb_unexpected_event", 32'(q), 32'hFFFF);
            else checkOutput("sb_q", 32'(q), 32'(expQ.pop_front()));
        end
    end

    function automatic void pushStep(input logic dir, input logic [5:0] s, input logic [5:0] e);
        logic [5:0] v;
        v = s;
        expQ.push_back(v);
        while (v != e) begin
            v = dir ? v + 6'd1 : v - 6'd1;
            expQ.push_back(v);
        end
    endfunction

    function automatic void pushMain();
        pushStep(1'b1, 6'd5, 6'd9);
        pushStep(1'b0, 6'd9, 6'd2);
        pushStep(1'b1, 6'd60, 6'd3);
        pushStep(1'b0, 6'd0, 6'd0);
    endfunction

    task automatic writeStep(input logic [1:0] addr, input logic dir, input logic [5:0] e, input logic [5:0] s);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = {dir, e, s};
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic loadMain();
        writeStep(2'd0, 1'b1, 6'd9, 6'd5);
        writeStep(2'd1, 1'b0, 6'd2, 6'd9);
        writeStep(2'd2, 1'b1, 6'd3, 6'd60);
        writeStep(2'd3, 1'b0, 6'd0, 6'd0);
    endtask

    task automatic applyStimulus(input logic s, input logic p);
        @(posedge clk); #1;
        start = s; stop = p;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic waitRunAt(input logic [5:0] val, input int budget, output bit found);
        found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (cnt_run && q == val) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit found;
        bit seen3;

        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_load_n", 32'(cnt_load_n), 32'd1);
        checkOutput("rst_run", 32'(cnt_run), 32'd0);
        checkOutput("rst_preset", 32'(cnt_preset), 32'd0);
        checkOutput("rst_up", 32'(cnt_up), 32'd1);
        checkOutput("rst_idx", 32'(step_idx), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] one-shot sequence through the main table");
        loadMain();
        expQ.delete(); pushMain();
        doneCount = 0; sbEn = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("seq_busy", 32'(busy), 32'd1);
        waitIdle("seq_finish", 3000);
        repeat (3) @(negedge clk);
        checkOutput("seq_sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("seq_done_pulses", 32'(doneCount), 32'd1);
        checkOutput("seq_busy_after", 32'(busy), 32'd0);
        sbEn = 1'b0;

        $display("[TB] zero-length step goes straight to dwell");
        writeStep(2'd0, 1'b1, 6'd10, 6'd10);
        runCount = 0;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("z_load_n", 32'(cnt_load_n), 32'd0);
        checkOutput("z_preset", 32'(cnt_preset), 32'd10);
        @(negedge clk);
        checkOutput("z_settle_load_n", 32'(cnt_load_n), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("z_dwell_idx", 32'(step_idx), 32'd0);
            checkOutput("z_dwell_load_n", 32'(cnt_load_n), 32'd1);
        end
        @(negedge clk);
        checkOutput("z_next_idx", 32'(step_idx), 32'd1);
        checkOutput("z_next_load_n", 32'(cnt_load_n), 32'd0);
        checkOutput("z_run_never", 32'(runCount), 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("z_stop_busy", 32'(busy), 32'd0);

        $display("[TB] looping sequence restarts at step 0");
        writeStep(2'd0, 1'b1, 6'd9, 6'd5);
        loop_en = 1'b1;
        expQ.delete(); pushMain(); expQ.push_back(6'd5);
        doneCount = 0; sbEn = 1'b1;
        applyStimulus(1'b1, 1'b0);
        found = 1'b0; seen3 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (step_idx == 2'd3) seen3 = 1'b1;
            if (seen3 && !cnt_load_n && step_idx == 2'd0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("loop_reload_seen", 32'(found), 32'd1);
        checkOutput("loop_preset", 32'(cnt_preset), 32'd5);
        checkOutput("loop_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("loop_sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("loop_no_done", 32'(doneCount), 32'd0);
        sbEn = 1'b0;
        applyStimulus(1'b0, 1'b1);
        loop_en = 1'b0;

        $display("[TB] stop while running");
        expQ.delete(); pushStep(1'b1, 6'd5, 6'd7);
        doneCount = 0; sbEn = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitRunAt(6'd7, 500, found);
        checkOutput("stop_reached_q7", 32'(found), 32'd1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        checkOutput("stop_run", 32'(cnt_run), 32'd0);
        checkOutput("stop_busy", 32'(busy), 32'd0);
        checkOutput("stop_idx", 32'(step_idx), 32'd0);
        checkOutput("stop_load_n", 32'(cnt_load_n), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("stop_q_held", 32'(q), 32'd7);
        checkOutput("stop_no_done", 32'(doneCount), 32'd0);
        checkOutput("stop_sb_drained", 32'(expQ.size()), 32'd0);
        sbEn = 1'b0;

        $display("[TB] ignored requests");
        applyStimulus(1'b1, 1'b1);
        checkOutput("ss_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("ss_load_n", 32'(cnt_load_n), 32'd1);
        expQ.delete(); pushMain();
        doneCount = 0; sbEn = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitRunAt(6'd6, 500, found);
        checkOutput("busy_reached_q6", 32'(found), 32'd1);
        @(posedge clk); #1;
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = {1'b1, 6'd40, 6'd40};
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        waitIdle("busy_seq_finish", 3000);
        repeat (3) @(negedge clk);
        checkOutput("busy_sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("busy_done_pulses", 32'(doneCount), 32'd1);
        sbEn = 1'b0;

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1'b1, 1'b0);
        waitRunAt(6'd5, 500, found);
        checkOutput("ar_reached_run", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("ar_busy", 32'(busy), 32'd0);
        checkOutput("ar_run", 32'(cnt_run), 32'd0);
        checkOutput("ar_load_n", 32'(cnt_load_n), 32'd1);
        checkOutput("ar_preset", 32'(cnt_preset), 32'd0);
        checkOutput("ar_up", 32'(cnt_up), 32'd1);
        checkOutput("ar_idx", 32'(step_idx), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        expQ.delete();
        for (int i = 0; i < 4; i++) expQ.push_back(6'd0);
        runCount = 0; doneCount = 0; sbEn = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitIdle("ar_table_finish", 500);
        repeat (3) @(negedge clk);
        checkOutput("ar_table_sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("ar_table_no_run", 32'(runCount), 32'd0);
        checkOutput("ar_table_done", 32'(doneCount), 32'd1);
        sbEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cnt_seq_ctrl.md
CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 SHALL have parameter F_CLK_HZ, default 25_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter DWELL_MS, default 500, pause at end of each step in ms; DWELL_TKS = max(1, F_CLK_HZ/1000*DWELL_MS).
REQ-003 SHALL have parameter N_STEPS, default 4, step-table depth (power of 2, >=2).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  synchronous one-cycle request to begin the sequence at step 0.
REQ-007 stop  in  1  synchronous abort request.
REQ-008 loop_en  in  1  1 = restart at step 0 after the last step; 0 = one-shot.
REQ-009 cfg_we  in  1  step-table write strobe.
REQ-010 cfg_addr  in  $clog2(N_STEPS)  step-table entry index.
REQ-011 cfg_data  in  13  {dir[12] (1=up), end_val[11:6], start_val[5:0]}.
REQ-012 q_in  in  6  current counter value fed back from the 6-bit preset counter.
REQ-013 cnt_load_n  out  1  active-low load to the counter.
REQ-014 cnt_preset  out  6  preset value to the counter.
REQ-015 cnt_run  out  1  drives the counter pause pin; 1 = count, 0 = hold.
REQ-016 cnt_up  out  1  drives the counter up_down pin; 1 = up.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 step_idx  out  $clog2(N_STEPS)  index of the step in progress.
REQ-019 done  out  1  one-cycle pulse on one-shot sequence completion.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, SETTLE, RUN, DWELL.
REQ-021 IDLE: start=1 and stop=0 -> LOAD with step_idx=0; start and stop together -> stay in IDLE.
REQ-022 LOAD: exactly 1 cycle with cnt_load_n=0, cnt_preset=start_val[step_idx], cnt_run=0; -> SETTLE.
REQ-023 SETTLE: 1 cycle, cnt_load_n=1, cnt_run=0; q_in==end_val -> DWELL, else -> RUN.
REQ-024 RUN: cnt_run=1, cnt_up=dir[step_idx]; the cycle q_in==end_val is sampled -> DWELL, with cnt_run=0 from the next cycle (no overshoot while counter tick period > 2 cycles).
REQ-025 Counting SHALL wrap mod 64 (up 62->63->0->1; down 1->0->63), so end_val is reachable from any start_val in either direction.
REQ-026 DWELL: cnt_run=0 for exactly DWELL_TKS cycles; then:
- step_idx < N_STEPS-1 -> step_idx+1, LOAD;
- last step and loop_en=1 -> step_idx=0, LOAD;
- last step and loop_en=0 -> IDLE, with done=1 for 1 cycle.
REQ-027 stop=1 in any non-IDLE state -> IDLE next cycle: cnt_run=0, cnt_load_n=1, step_idx=0, no done pulse.
REQ-028 start while busy SHALL be ignored.
REQ-029 cfg_we SHALL write the table only in IDLE; writes while busy SHALL be dropped.
REQ-030 Table fields SHALL be read only on LOAD entry; cnt_up SHALL be held stable for the whole step.
REQ-031 In IDLE, outputs SHALL be cnt_load_n=1, cnt_run=0, cnt_preset=0, cnt_up=1.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, step_idx=0, dwell counter=0, all table entries to 13'h1000 (up, 0->0), and IDLE output values with done=0, busy=0.
REQ-033 Reset SHALL take effect mid-sequence with no further load pulse.

Structure
REQ-034 Package cnt_seq_pkg SHALL hold the state enum, the step_t struct {dir, end_val, start_val}, and the field widths.
REQ-035 Sub-module step_table (N_STEPS x step_t register file, 1 write port, 1 async read port) SHALL be instantiated once; the FSM and dwell counter stay in cnt_seq_ctrl.

Verification (F_CLK_HZ=4000, DWELL_MS=1 -> DWELL_TKS=4; counter model ticks every 8 cycles)
REQ-036 Table {up 5->9, down 9->2, up 60->3, down 0->0}, loop_en=0, start -> q sequence 5..9, 9..2, 60,61,62,63,0..3, 0; one done pulse; busy low afterwards.
REQ-037 Step up 10->10 -> LOAD, SETTLE, DWELL (4 cycles); cnt_run never 1.
REQ-038 loop_en=1 -> after step 3 DWELL, step_idx=0 and cnt_load_n low with cnt_preset=5; no done pulse.
REQ-039 stop during RUN at q=7 -> cnt_run=0 next cycle; q stays 7; busy=0; step_idx=0.
REQ-040 start+stop in IDLE, start while busy, cfg_we while busy -> no state change and table contents unchanged.
REQ-041 reset_n low mid-RUN -> outputs reach IDLE values asynchronously; table reads back 13'h1000 for all entries.
